mmio_console: RTL and testbench

//  Memory-mapped console responder on the CPU data bus, alongside mem. Decodes a small

---
 rtl/mmio_console.sv | 130 +++++++++++++
 tb/tb_mmio_console.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_console.sv
// mmio_console: memory-mapped console responder.
// A 16-byte register window on the CPU data bus. Stores to TXDATA are queued in a
// small circular TX FIFO that drains to an external byte sink over valid/ready.
// STATUS reports FIFO state plus a sticky overflow flag. CYCLES is a free-running
// 32-bit timebase that software can clear.
module mmio_console #(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
  parameter int          FIFO_DEPTH = 8,
  localparam int         CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic        con_clk,
  input  logic        con_rst,
  input  logic [31:0] con_addr,
  input  logic        con_rd,
  input  logic        con_wr,
  input  logic [31:0] con_wr_data,
  output logic [31:0] con_rd_data,
  output logic        con_sel,
  output logic [7:0]  con_out_data,
  output logic        con_out_valid,
  input  logic        con_out_ready
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CYCLES = 2'd2;

  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;
  logic [31:0]      r_cycles;

  logic [1:0]  w_off;
  logic        w_empty;
  logic        w_full;
  logic        w_push;
  logic        w_pop;
  logic        w_accept;
  logic        w_drop;
  logic        w_status_wr;
  logic        w_cycles_wr;
  logic [8:0]  w_cnt_ext;
  logic [31:0] w_status;
  logic        w_unused;

  // Byte-lane bits and upper store data have no meaning in this window.
  assign w_unused = ^{con_addr[1:0], con_wr_data[31:8]};

  assign con_sel     = (con_addr[31:4] == BASE_ADDR[31:4]);
  assign w_off       = con_addr[3:2];
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_push      = con_sel && con_wr && (w_off == OFF_TXDATA);
  assign w_status_wr = con_sel && con_wr && (w_off == OFF_STATUS);
  assign w_cycles_wr = con_sel && con_wr && (w_off == OFF_CYCLES);
  assign w_pop       = !w_empty && con_out_ready;
  // When full, a push only fits if the head leaves on the same edge.
  assign w_accept    = w_push && (!w_full || w_pop);
  assign w_drop      = w_push && w_full && !w_pop;

  assign con_out_valid = !w_empty;
  // Head is masked to zero while empty so reset shows 8'h00 without clearing storage.
  assign con_out_data  = w_empty ? 8'h00 : r_mem[r_rd_ptr];

  assign w_cnt_ext = 9'(r_count);
  assign w_status  = {16'h0000, w_cnt_ext[7:0], 5'b00000, r_ovf, w_full, w_empty};

  // FIFO storage: written on accepted pushes only, never reset.
  always_ff @(posedge con_clk) begin
    if (w_accept) begin
      r_mem[r_wr_ptr] <= con_wr_data[7:0];
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge con_clk or posedge con_rst) begin
    if (con_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow: a dropped byte outranks a same-cycle clear.
  always_ff @(posedge con_clk or posedge con_rst) begin
    if (con_rst) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (w_status_wr) begin
      r_ovf <= 1'b0;
    end
  end

  // Free-running cycle counter; a software clear outranks the increment.
  always_ff @(posedge con_clk or posedge con_rst) begin
    if (con_rst) begin
      r_cycles <= '0;
    end else if (w_cycles_wr) begin
      r_cycles <= '0;
    end else begin
      r_cycles <= r_cycles + 32'd1;
    end
  end

  // Combinational read mux; zero unless this window is being read.
  always_comb begin
    con_rd_data = 32'h0;
    if (con_sel && con_rd) begin
      case (w_off)
        OFF_STATUS: con_rd_data = w_status;
        OFF_CYCLES: con_rd_data = r_cycles;
        default:    con_rd_data = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_console.sv
// Testbench for mmio_console: directed scenarios plus randomized traffic, each
// cycle compared against a queue-based behavioural model of the console.
module tb_mmio_console;

  localparam logic [31:0] BASE  = 32'hFFFF_0000;
  localparam int          DEPTH = 8;

  logic        con_clk;
  logic        con_rst;
  logic [31:0] con_addr;
  logic        con_rd;
  logic        con_wr;
  logic [31:0] con_wr_data;
  logic [31:0] con_rd_data;
  logic        con_sel;
  logic [7:0]  con_out_data;
  logic        con_out_valid;
  logic        con_out_ready;

  mmio_console #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
    .con_clk       (con_clk),
    .con_rst       (con_rst),
    .con_addr      (con_addr),
    .con_rd        (con_rd),
    .con_wr        (con_wr),
    .con_wr_data   (con_wr_data),
    .con_rd_data   (con_rd_data),
    .con_sel       (con_sel),
    .con_out_data  (con_out_data),
    .con_out_valid (con_out_valid),
    .con_out_ready (con_out_ready)
  );

  initial con_clk = 1'b0;
  always #5 con_clk = ~con_clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0]  m_q[$];
  logic        m_ovf;
  logic [31:0] m_cyc;
  logic [31:0] last_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [31:0] a, input logic rd);
    logic [31:0] v;
    logic [7:0]  cnt;
    v   = 32'h0;
    cnt = 8'(m_q.size());
    if (a[31:4] == BASE[31:4] && rd) begin
      case (a[3:2])
        2'd1: v = {16'h0000, cnt, 5'b00000, m_ovf,
                   (m_q.size() == DEPTH), (m_q.size() == 0)};
        2'd2: v = m_cyc;
        default: v = 32'h0;
      endcase
    end
    return v;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_ovf = 1'b0;
    m_cyc = 32'h0;
  endtask

  // One bus cycle: drive after the falling edge, check before the rising edge,
  // advance the model across the edge, return at the next falling edge.
  task automatic cyc(input logic [31:0] a, input logic rd, input logic wr,
                     input logic [31:0] wd, input logic rdy);
    logic sel, push, pop, ovf_set;
    int   sz;
    con_addr      = a;
    con_rd        = rd;
    con_wr        = wr;
    con_wr_data   = wd;
    con_out_ready = rdy;
    #1;
    sel = (a[31:4] == BASE[31:4]);
    check("sel",   {31'h0, con_sel}, {31'h0, sel});
    check("rdata", con_rd_data, model_rd(a, rd));
    check("valid", {31'h0, con_out_valid}, {31'h0, (m_q.size() != 0)});
    check("odata", {24'h0, con_out_data}, {24'h0, (m_q.size() != 0) ? m_q[0] : 8'h00});
    last_rd = con_rd_data;
    @(posedge con_clk);
    sz      = m_q.size();
    push    = sel && wr && (a[3:2] == 2'd0);
    pop     = (sz != 0) && rdy;
    ovf_set = 1'b0;
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (sz == DEPTH && !pop) ovf_set = 1'b1;
      else m_q.push_back(wd[7:0]);
    end
    if (ovf_set) m_ovf = 1'b1;
    else if (sel && wr && a[3:2] == 2'd1) m_ovf = 1'b0;
    m_cyc = (sel && wr && a[3:2] == 2'd2) ? 32'h0 : m_cyc + 32'd1;
    @(negedge con_clk);
  endtask

  // Asynchronous reset pulse between clock edges, checked with no clock edge.
  task automatic async_reset();
    con_addr      = BASE + 32'd4;
    con_rd        = 1'b1;
    con_wr        = 1'b0;
    con_wr_data   = 32'h0;
    con_out_ready = 1'b0;
    #1 con_rst = 1'b1;
    #1;
    model_reset();
    check("rst_valid",  {31'h0, con_out_valid}, 32'h0);
    check("rst_odata",  {24'h0, con_out_data}, 32'h0);
    check("rst_status", con_rd_data, 32'h0000_0001);
    con_rst = 1'b0;
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b, input logic rdy);
    cyc(BASE, 1'b0, 1'b1, {24'h0, b}, rdy);
  endtask

  task automatic idle(input logic rdy);
    cyc(32'h0000_1000, 1'b0, 1'b0, 32'h0, rdy);
  endtask

  initial begin
    con_rst       = 1'b1;
    con_addr      = 32'h0;
    con_rd        = 1'b0;
    con_wr        = 1'b0;
    con_wr_data   = 32'h0;
    con_out_ready = 1'b0;
    model_reset();
    last_rd = 32'h0;
    @(negedge con_clk);
    con_rst = 1'b0;

    // Post-reset reads
    cyc(BASE + 32'd8, 1'b1, 1'b0, 32'h0, 1'b0);
    check("t1_cycles0", last_rd, 32'h0);
    cyc(BASE + 32'd4, 1'b1, 1'b0, 32'h0, 1'b0);
    check("t1_status", last_rd, 32'h0000_0001);

    // "Hi" through the FIFO with the sink always ready
    async_reset();
    push_byte(8'h48, 1'b1);
    check("t2_h", {24'h0, con_out_data}, 32'h48);
    push_byte(8'h69, 1'b1);
    check("t2_i", {24'h0, con_out_data}, 32'h69);
    idle(1'b1);
    check("t2_drop_valid", {31'h0, con_out_valid}, 32'h0);

    // Overflow with a stalled sink, ordered drain, overflow clear
    async_reset();
    for (int i = 0; i < 9; i++) push_byte(8'(i), 1'b0);
    cyc(BASE + 32'd4, 1'b1, 1'b0, 32'h0, 1'b0);
    check("t3_status_full", last_rd, 32'h0000_0806);
    for (int i = 0; i < 8; i++) begin
      check("t3_order", {24'h0, con_out_data}, i);
      idle(1'b1);
    end
    cyc(BASE + 32'd4, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
    cyc(BASE + 32'd5, 1'b1, 1'b0, 32'h0, 1'b0);
    check("t3_ovf_clr", last_rd, 32'h0000_0001);

    // Push and pop on the same edge while full
    for (int i = 0; i < 8; i++) push_byte(8'h10 + 8'(i), 1'b0);
    push_byte(8'hAA, 1'b1);
    cyc(BASE + 32'd4, 1'b1, 1'b0, 32'h0, 1'b0);
    check("t4_status", last_rd, 32'h0000_0802);
    for (int i = 0; i < 7; i++) idle(1'b1);
    check("t4_last", {24'h0, con_out_data}, 32'hAA);
    idle(1'b1);

    // Cycle counter clear, count, and wrap
    cyc(BASE + 32'd8, 1'b0, 1'b1, 32'h1234, 1'b0);
    for (int i = 0; i < 10; i++) idle(1'b0);
    cyc(BASE + 32'd8, 1'b1, 1'b0, 32'h0, 1'b0);
    check("t5_cycles10", last_rd, 32'd10);
    force dut.r_cycles = 32'hFFFF_FFFE;
    #1 release dut.r_cycles;
    m_cyc = 32'hFFFF_FFFE;
    cyc(BASE + 32'd8, 1'b1, 1'b0, 32'h0, 1'b0);
    cyc(BASE + 32'd8, 1'b1, 1'b0, 32'h0, 1'b0);
    check("t5_max", last_rd, 32'hFFFF_FFFF);
    cyc(BASE + 32'd8, 1'b1, 1'b0, 32'h0, 1'b0);
    check("t5_wrap", last_rd, 32'h0);

    // Reset in the middle of a drain
    for (int i = 0; i < 7; i++) push_byte(8'h30 + 8'(i), 1'b0);
    idle(1'b1);
    idle(1'b1);
    check("t6_count5", {24'h0, 8'(m_q.size())}, 32'd5);
    async_reset();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [31:0] a;
      if ($urandom_range(0, 99) < 2) begin
        async_reset();
      end else begin
        if ($urandom_range(0, 9) < 9)
          a = {BASE[31:4], 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
        else
          a = $urandom;
        cyc(a, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 5),
            $urandom, ($urandom_range(0, 9) < 4));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
